uart_tx: RTL and testbench

Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serializes each one as an 8N1 frame (optionally 8E1/8O1), LSB first, at CLKS_PER_BIT clocks per bit. It is the transmit half of the team's UART link, pairing with the existing 8N1 receiver at the same CLKS_PER_BIT. The FIFO lets the host queue several bytes and sends them back-to-back with no idle bits between frames.

---
 rtl/uart_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx -- buffered UART transmitter.
//
// Accepts bytes over a valid/ready handshake into a small FIFO and sends each
// one as an 8N1 frame (8E1/8O1 when PARITY_EN=1), LSB first, at CLKS_PER_BIT
// clocks per bit. Queued bytes go out back-to-back with no idle bits between
// frames.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (f_clk / baud), minimum 2
//   FIFO_DEPTH    byte FIFO depth, power of 2, minimum 2
//   PARITY_EN     1 inserts a parity bit between D7 and stop
//   PARITY_ODD    0 even parity, 1 odd parity (ignored when PARITY_EN=0)
//
// Ports:
//   i_Clock      sole clock, rising edge
//   i_Reset      synchronous active-high reset; aborts any frame, flushes FIFO
//   i_TX_DV      byte valid
//   i_TX_Byte    byte to send, captured on accept
//   o_TX_Ready   FIFO not full; accept = i_TX_DV && o_TX_Ready at a clock edge
//   o_TX_Serial  serial line, idle high, registered
//   o_TX_Active  high while a frame is on the line
//   o_TX_Done    one-cycle pulse on the last clock of each stop bit

module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);
    localparam logic              HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       head;

    // A write presented while full is refused even on a pop edge; the host
    // keeps i_TX_DV up and the byte is taken on the following edge.
    assign o_TX_Ready = (count != CNT_FULL);
    assign fifo_empty = (count == '0);
    assign push       = i_TX_DV && o_TX_Ready;
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t            state;
    logic [BCNT_W-1:0] bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              parity_bit;
    logic              bit_last;

    assign bit_last = (bit_cnt == BCNT_LAST);

    // The FSM takes the FIFO head from IDLE, or on the final stop-bit clock
    // so the next start bit follows with no idle gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == STOP && bit_last) begin
                pop = 1'b1;
            end
        end
    end

    // Line outputs are registered from the current state, so the line lags
    // the state register by one clock; o_TX_Done lags the same way and so
    // lines up with the last stop-bit clock actually on the wire.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            o_TX_Done <= 1'b0;
            case (state)
                IDLE: begin
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                    bit_cnt     <= '0;
                    bit_idx     <= '0;
                    if (pop) begin
                        shift      <= head;
                        parity_bit <= (^head) ^ ODD_BIT;
                        state      <= START;
                    end
                end

                START: begin
                    o_TX_Serial <= 1'b0;
                    o_TX_Active <= 1'b1;
                    if (bit_last) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                    end
                end

                DATA: begin
                    o_TX_Serial <= shift[0];
                    o_TX_Active <= 1'b1;
                    if (bit_last) begin
                        bit_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= HAS_PAR ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                    end
                end

                PARITY: begin
                    o_TX_Serial <= parity_bit;
                    o_TX_Active <= 1'b1;
                    if (bit_last) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                    end
                end

                STOP: begin
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b1;
                    if (bit_last) begin
                        bit_cnt   <= '0;
                        o_TX_Done <= 1'b1;
                        if (pop) begin
                            shift      <= head;
                            parity_bit <= (^head) ^ ODD_BIT;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                    end
                end

                default: begin
                    state       <= IDLE;
                    bit_cnt     <= '0;
                    bit_idx     <= '0;
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Three instances at CLKS_PER_BIT=4, FIFO_DEPTH=4: index 0 is 8N1, index 1
// is 8E1, index 2 is 8O1. Stimulus pushes the expected frame of every
// accepted byte into a queue; a per-instance monitor decodes the serial line
// and pops/compares whenever a frame appears.

module tb_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       dv     [3];
    logic [7:0] din    [3];
    logic       ready  [3];
    logic       serial [3];
    logic       active [3];
    logic       done   [3];

    int          cyc;
    int          n_cmp;
    int          n_err;
    int          run      [3];
    int          last_run [3];
    int          done_cnt [3];
    logic [10:0] last_bits [3];

    exp_t       exp_q[$];
    int         start_q[$];
    int         acc_q[$];
    logic       rdy_after_q[$];
    logic [7:0] bq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (active[g] === 1'b1) begin
                run[g] <= run[g] + 1;
            end else begin
                if (run[g] != 0) last_run[g] <= run[g];
                run[g] <= 0;
            end
            if (done[g] === 1'b1) done_cnt[g] <= done_cnt[g] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode one frame whose first start-bit sample is the current negedge.
    task automatic monitor_frame(input int g);
        int          nb;
        int          ns;
        int          done_at;
        int          done_n;
        logic [43:0] s;
        logic [10:0] bits;
        logic        act_ok;
        logic        stable;
        logic        aborted;
        exp_t        e;
        nb = (g == 0) ? 10 : 11;
        ns = nb * CPB;
        s = '0; bits = '0;
        act_ok = 1'b1; stable = 1'b1; aborted = 1'b0;
        done_at = -1; done_n = 0;
        start_q.push_back(cyc);
        for (int i = 0; i < ns; i++) begin
            if (i > 0) @(negedge clk);
            if (rst) begin
                aborted = 1'b1;
                break;
            end
            s[i] = serial[g];
            if (active[g] !== 1'b1) act_ok = 1'b0;
            if (done[g] === 1'b1) begin
                done_n++;
                done_at = i;
            end
        end
        if (!aborted) begin
            for (int b = 0; b < nb; b++) begin
                bits[b] = s[b*CPB];
                for (int c = 1; c < CPB; c++)
                    if (s[b*CPB+c] !== bits[b]) stable = 1'b0;
            end
            last_bits[g] = bits;
            check("frame_bit_stable", 32'(stable), 1);
            check("frame_start_bit", 32'(bits[0]), 0);
            check("frame_stop_bit", 32'(bits[nb-1]), 1);
            check("frame_active", 32'(act_ok), 1);
            check("frame_done_pos", done_at, ns - 1);
            check("frame_done_once", done_n, 1);
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("frame_dut", g, e.dut);
                check("frame_data", 32'(bits[8:1]), 32'(e.data));
                if (g != 0) check("frame_parity", 32'(bits[9]), 32'(e.par));
            end
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(CPB),
            .FIFO_DEPTH  (4),
            .PARITY_EN   ((g > 0) ? 1 : 0),
            .PARITY_ODD  ((g == 2) ? 1 : 0)
        ) u_dut (
            .i_Clock    (clk),
            .i_Reset    (rst),
            .i_TX_DV    (dv[g]),
            .i_TX_Byte  (din[g]),
            .o_TX_Ready (ready[g]),
            .o_TX_Serial(serial[g]),
            .o_TX_Active(active[g]),
            .o_TX_Done  (done[g])
        );

        initial begin
            forever begin
                @(negedge clk);
                if (rst === 1'b0 && serial[g] === 1'b0) monitor_frame(g);
            end
        end
    end

    // Called at a negedge; holds i_TX_DV until every byte is accepted.
    task automatic push_seq(input int g, input logic [7:0] bytes[$], input logic par);
        int   i;
        int   guard;
        logic r;
        exp_t e;
        i = 0;
        guard = 0;
        while (i < bytes.size() && guard < 2000) begin
            dv[g]  = 1'b1;
            din[g] = bytes[i];
            r      = ready[g];
            @(posedge clk);
            #1;
            if (r) begin
                e.dut = g; e.data = bytes[i]; e.par = par;
                exp_q.push_back(e);
                acc_q.push_back(cyc);
                i++;
            end
            @(negedge clk);
            if (r) rdy_after_q.push_back(ready[g]);
            guard++;
        end
        dv[g]  = 1'b0;
        din[g] = 8'hEE;
        if (i < bytes.size()) check("push_timeout", i, bytes.size());
    endtask

    task automatic wait_idle(input int g);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || active[g] !== 1'b0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) check("wait_idle_timeout", guard, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_logs();
        start_q.delete();
        acc_q.delete();
        rdy_after_q.delete();
        bq.delete();
    endtask

    initial begin
        int d0;
        int guard;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            dv[g]  = 1'b0;
            din[g] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        for (int g = 0; g < 3; g++) begin
            check("rst_serial", 32'(serial[g]), 1);
            check("rst_active", 32'(active[g]), 0);
            check("rst_done", 32'(done[g]), 0);
            check("rst_ready", 32'(ready[g]), 1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xA5
        clear_logs();
        d0 = done_cnt[0];
        bq.push_back(8'hA5);
        push_seq(0, bq, 1'b0);
        wait_idle(0);
        check("t1_frames", start_q.size(), 1);
        if (start_q.size() == 1) check("t1_latency", start_q[0] - acc_q[0], 2);
        check("t1_line_bits", 32'(last_bits[0][9:0]), 32'(10'b1101001010));
        check("t1_done_count", done_cnt[0] - d0, 1);
        check("t1_active_len", last_run[0], 40);
        check("t1_active_low", 32'(active[0]), 0);

        // Back-to-back 0x00, 0xFF, 0x3C
        clear_logs();
        d0 = done_cnt[0];
        bq.push_back(8'h00); bq.push_back(8'hFF); bq.push_back(8'h3C);
        push_seq(0, bq, 1'b0);
        wait_idle(0);
        check("t2_accept_span", acc_q[2] - acc_q[0], 2);
        check("t2_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("t2_gap_1", start_q[1] - start_q[0], 40);
            check("t2_gap_2", start_q[2] - start_q[1], 40);
        end
        check("t2_done_count", done_cnt[0] - d0, 3);
        check("t2_active_len", last_run[0], 120);

        // Full FIFO plus push on the STOP->START pop edge
        clear_logs();
        d0 = done_cnt[0];
        bq.push_back(8'h10);
        push_seq(0, bq, 1'b0);
        bq.delete();
        bq.push_back(8'h21); bq.push_back(8'h32); bq.push_back(8'h43);
        bq.push_back(8'h54); bq.push_back(8'h65); bq.push_back(8'h76);
        push_seq(0, bq, 1'b0);
        wait_idle(0);
        check("t3_accepts", acc_q.size(), 7);
        check("t3_frames", start_q.size(), 7);
        if (acc_q.size() == 7 && start_q.size() == 7) begin
            check("t3_fill_span", acc_q[4] - acc_q[1], 3);
            check("t3_ready_cnt3", 32'(rdy_after_q[3]), 1);
            check("t3_ready_full", 32'(rdy_after_q[4]), 0);
            check("t3_accept_after_pop1", acc_q[5] - start_q[0], 40);
            check("t3_refull", 32'(rdy_after_q[5]), 0);
            check("t3_accept_after_pop2", acc_q[6] - start_q[0], 80);
            check("t3_contiguous", start_q[6] - start_q[0], 240);
        end
        check("t3_done_count", done_cnt[0] - d0, 7);

        // Parity even then odd on 0x07
        clear_logs();
        bq.push_back(8'h07);
        push_seq(1, bq, 1'b1);
        wait_idle(1);
        check("t4_even_parity_bit", 32'(last_bits[1][9]), 1);
        check("t4_even_len", last_run[1], 44);
        push_seq(2, bq, 1'b0);
        wait_idle(2);
        check("t4_odd_parity_bit", 32'(last_bits[2][9]), 0);
        check("t4_odd_len", last_run[2], 44);

        // Reset during DATA bit 3 with two bytes queued
        clear_logs();
        bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
        push_seq(0, bq, 1'b0);
        guard = 0;
        while (start_q.size() == 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t5_frame_started", start_q.size(), 1);
        guard = 0;
        while (start_q.size() > 0 && cyc < start_q[0] + 17 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        d0 = done_cnt[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_line_high", 32'(serial[0]), 1);
        check("t5_active_low", 32'(active[0]), 0);
        check("t5_ready", 32'(ready[0]), 1);
        check("t5_done_low", 32'(done[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (80) @(negedge clk);
        check("t5_no_done", done_cnt[0] - d0, 0);
        check("t5_fifo_flushed", start_q.size(), 1);
        check("t5_ready_after", 32'(ready[0]), 1);
        bq.delete();
        bq.push_back(8'h5A);
        push_seq(0, bq, 1'b0);
        wait_idle(0);
        check("t5_post_frames", start_q.size(), 2);
        check("t5_post_data", 32'(last_bits[0][8:1]), 32'h5A);
        check("t5_post_done", done_cnt[0] - d0, 1);

        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
